// File: rtl/lookahead_ram_pkg.sv
// Shared types and elaboration helpers for the lookahead multiport RAM.
`timescale 1ns/1ps
package lookahead_ram_pkg;

    // Write-port life cycle: zero-fill, one-cycle settle, or open for traffic.
    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        READY_PEND = 2'd1,
        READY      = 2'd2
    } ram_state_e;

    // Number of byte-enable lanes in one word.
    function automatic int num_lanes(input int data_width, input int symbol_width);
        return data_width / symbol_width;
    endfunction

    // True when the address bus is wide enough to reach every word.
    function automatic bit addr_width_ok(input int address_width, input int depth);
        return address_width >= $clog2(depth);
    endfunction

endpackage

// File: rtl/lookahead_ram_rdport.sv
// One read port: range check, registered lookahead bypass and output hold.
`timescale 1ns/1ps
module lookahead_ram_rdport
    import lookahead_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SYMBOL_WIDTH  = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 4,
    localparam int NUM_LANES    = num_lanes(DATA_WIDTH, SYMBOL_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    input  logic                     rd_read,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     wr_accept,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]    wr_writedata,
    input  logic [NUM_LANES-1:0]     wr_byteenable,
    output logic [DATA_WIDTH-1:0]    rd_readdata
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic                  in_range;
    logic [DATA_WIDTH-1:0] arr_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic [NUM_LANES-1:0]  be_q;
    logic                  byp_q;

    assign in_range = ({1'b0, rd_address} < DEPTH_L);

    // Capture old array contents plus any same-cycle write; hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            arr_q <= '0;
            wd_q  <= '0;
            be_q  <= '0;
            byp_q <= 1'b0;
        end else if (rd_read) begin
            if (ready && in_range) begin
                arr_q <= mem_rdata;
                byp_q <= wr_accept && (wr_address == rd_address);
                be_q  <= wr_byteenable;
                wd_q  <= wr_writedata;
            end else begin
                arr_q <= '0;
                byp_q <= 1'b0;
            end
        end
    end

    // Merge the captured write over the old word, lane by lane.
    always_comb begin
        rd_readdata = arr_q;
        if (byp_q) begin
            for (int s = 0; s < NUM_LANES; s++) begin
                if (be_q[s]) begin
                    rd_readdata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH] = wd_q[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/lookahead_mport_ram.sv
// Lookahead multiport RAM: one byte-masked write port, NUM_RD_PORTS read ports,
// optional zero-fill after reset.
//
// Write handshake: a write is taken on a rising edge when wr_write=1 and
// wr_waitrequest=0 at that edge (and the address is inside DEPTH). While
// wr_waitrequest=1 writes are discarded, never queued. Reads have no
// handshake: rd_read[p] samples an address and the result appears one edge later.
`timescale 1ns/1ps
module lookahead_mport_ram
    import lookahead_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYMBOL_WIDTH   = 8,
    parameter int DEPTH          = 16,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int NUM_RD_PORTS   = 2,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NUM_LANES     = num_lanes(DATA_WIDTH, SYMBOL_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ADDRESS_WIDTH-1:0]             wr_address,
    input  logic [DATA_WIDTH-1:0]                wr_writedata,
    input  logic [NUM_LANES-1:0]                 wr_byteenable,
    input  logic                                 wr_write,
    output logic                                 wr_waitrequest,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_address,
    input  logic [NUM_RD_PORTS-1:0]              rd_read,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_readdata
);

    localparam int                     IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_L     = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] CLR_START = ADDRESS_WIDTH'(DEPTH - 1);
    localparam ram_state_e             RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY_PEND;

    if (!addr_width_ok(ADDRESS_WIDTH, DEPTH)) begin : g_bad_address_width
        $error("ADDRESS_WIDTH too small for DEPTH");
    end

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    ram_state_e               state;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;
    logic                     ready;
    logic                     clear_wr;
    logic                     wr_accept;

    assign ready     = (state == READY);
    assign clear_wr  = !reset && (state == CLEAR);
    assign wr_accept = !reset && wr_write && !wr_waitrequest && ({1'b0, wr_address} < DEPTH_L);

    // Clear/ready FSM with registered waitrequest; the counter stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RESET_STATE;
            clr_cnt        <= CLR_START;
            wr_waitrequest <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        state          <= READY;
                        wr_waitrequest <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                READY_PEND: begin
                    state          <= READY;
                    wr_waitrequest <= 1'b0;
                end
                READY: begin
                    wr_waitrequest <= 1'b0;
                end
                default: begin
                    state          <= RESET_STATE;
                    wr_waitrequest <= 1'b1;
                end
            endcase
        end
    end

    // Array write: zero-fill while clearing, otherwise byte-masked user writes.
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem[clr_cnt[IDX_W-1:0]] <= '0;
        end else if (wr_accept) begin
            for (int s = 0; s < NUM_LANES; s++) begin
                if (wr_byteenable[s]) begin
                    mem[wr_address[IDX_W-1:0]][s*SYMBOL_WIDTH +: SYMBOL_WIDTH]
                        <= wr_writedata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    rdata;

        assign addr  = rd_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign rdata = ({1'b0, addr} < DEPTH_L) ? mem[addr[IDX_W-1:0]] : '0;

        lookahead_ram_rdport #(
            .DATA_WIDTH    (DATA_WIDTH),
            .SYMBOL_WIDTH  (SYMBOL_WIDTH),
            .DEPTH         (DEPTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_rdport (
            .clk           (clk),
            .reset         (reset),
            .ready         (ready),
            .rd_read       (rd_read[p]),
            .rd_address    (addr),
            .mem_rdata     (rdata),
            .wr_accept     (wr_accept),
            .wr_address    (wr_address),
            .wr_writedata  (wr_writedata),
            .wr_byteenable (wr_byteenable),
            .rd_readdata   (rd_readdata[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_lookahead_mport_ram.sv
// Bench for lookahead_mport_ram: a 16-word, 2-port cleared instance against a
// scoreboard model, plus a 17-word uncleared instance for range checks.
`timescale 1ns/1ps
module tb_lookahead_mport_ram;

  localparam int DW = 32;
  localparam int SW = 8;
  localparam int NL = DW / SW;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int NP = 2;
  localparam int CLEAR_CYCLES = DEPTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic [AW-1:0] wr_address = '0;
  logic [DW-1:0] wr_writedata = '0;
  logic [NL-1:0] wr_byteenable = '0;
  logic wr_write = 1'b0;
  logic wr_waitrequest;
  logic [NP*AW-1:0] rd_address = '0;
  logic [NP-1:0] rd_read = '0;
  logic [NP*DW-1:0] rd_readdata;

  logic reset_b = 1'b1;
  logic [4:0] wr_address_b = '0;
  logic [DW-1:0] wr_writedata_b = '0;
  logic [NL-1:0] wr_byteenable_b = '0;
  logic wr_write_b = 1'b0;
  logic wr_waitrequest_b;
  logic [4:0] rd_address_b = '0;
  logic [0:0] rd_read_b = '0;
  logic [DW-1:0] rd_readdata_b;

  lookahead_mport_ram #(
    .DATA_WIDTH(DW), .SYMBOL_WIDTH(SW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW),
    .NUM_RD_PORTS(NP), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_address(wr_address), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_write(wr_write),
    .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address), .rd_read(rd_read), .rd_readdata(rd_readdata)
  );

  lookahead_mport_ram #(
    .DATA_WIDTH(DW), .SYMBOL_WIDTH(SW), .DEPTH(17), .ADDRESS_WIDTH(5),
    .NUM_RD_PORTS(1), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clk(clk), .reset(reset_b),
    .wr_address(wr_address_b), .wr_writedata(wr_writedata_b),
    .wr_byteenable(wr_byteenable_b), .wr_write(wr_write_b),
    .wr_waitrequest(wr_waitrequest_b),
    .rd_address(rd_address_b), .rd_read(rd_read_b), .rd_readdata(rd_readdata_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int port_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every port's registered output is compared right after each edge.
  initial begin
    int p;
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        p = port_q.pop_front();
        e = exp_q.pop_front();
        check($sformatf("rd_readdata_p%0d", p), rd_readdata[p*DW +: DW], e);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem[DEPTH];
  logic [DW-1:0] m_out[NP];
  int m_left = CLEAR_CYCLES;

  // ---------------- driver ----------------
  task automatic do_cycle(input bit rst, input bit we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [NL-1:0] be,
                          input logic [NP-1:0] rr, input logic [NP*AW-1:0] ra,
                          output bit wq);
    bit acc;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    @(negedge clk);
    reset = rst;
    wr_write = we;
    wr_address = wa;
    wr_writedata = wd;
    wr_byteenable = be;
    rd_read = rr;
    rd_address = ra;
    wq = wr_waitrequest;
    if (!rst) check("wr_waitrequest", 32'(wr_waitrequest), 32'(m_left != 0));
    acc = !rst && we && (m_left == 0) && (int'(wa) < DEPTH);
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        m_out[p] = '0;
      end else if (rr[p]) begin
        a = ra[p*AW +: AW];
        if (m_left != 0 || int'(a) >= DEPTH) begin
          v = '0;
        end else begin
          v = m_mem[a];
          if (acc && a == wa) begin
            for (int s = 0; s < NL; s++) if (be[s]) v[s*SW +: SW] = wd[s*SW +: SW];
          end
        end
        m_out[p] = v;
      end
      exp_q.push_back(m_out[p]);
      port_q.push_back(p);
    end
    if (acc) begin
      for (int s = 0; s < NL; s++) if (be[s]) m_mem[wa][s*SW +: SW] = wd[s*SW +: SW];
    end
    if (rst) begin
      m_left = CLEAR_CYCLES;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end
    @(posedge clk);
  endtask

  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NL-1:0] be, input logic [NP-1:0] rr, input logic [NP*AW-1:0] ra);
    bit wq;
    do_cycle(1'b0, we, wa, wd, be, rr, ra, wq);
  endtask

  task automatic do_reset(input int cycles);
    bit wq;
    for (int i = 0; i < cycles; i++) do_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, wq);
  endtask

  // Counts idle cycles with waitrequest high after reset release, bounded.
  task automatic count_wait(input string name, input int want);
    bit wq;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, wq);
      if (wq) cnt++;
      else break;
    end
    check(name, 32'(cnt), 32'(want));
  endtask

  task automatic step_b(input bit we, input logic [4:0] wa, input logic [DW-1:0] wd,
                        input bit rr, input logic [4:0] ra);
    @(negedge clk);
    wr_write_b = we;
    wr_address_b = wa;
    wr_writedata_b = wd;
    wr_byteenable_b = 4'hF;
    rd_read_b = rr;
    rd_address_b = ra;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NP*AW-1:0] ra;
    logic [NP-1:0] rr;
    bit rst;
    bit wq;

    // Reset and zero-fill: 16 waitrequest cycles, then every word reads zero.
    do_reset(3);
    count_wait("clear_cycles", CLEAR_CYCLES);
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 2'b11, {AW'(a), AW'(a)});

    // Reset five cycles into the clear restarts the full fill.
    step(1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 2'b00, '0);
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, '0, 2'b00, '0);
    do_reset(1);
    count_wait("midclear_cycles", CLEAR_CYCLES);
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 2'b11, {AW'(a), AW'(DEPTH - 1 - a)});
    #2;
    check("midclear_addr0_p0", rd_readdata[0 +: DW], 32'h0);

    // Full bypass on both ports.
    step(1'b1, 4'd3, 32'h11223344, 4'hF, 2'b00, '0);
    step(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 2'b11, {4'd3, 4'd3});
    #2;
    check("full_bypass_p0", rd_readdata[0 +: DW], 32'hAABBCCDD);
    check("full_bypass_p1", rd_readdata[DW +: DW], 32'hAABBCCDD);
    step(1'b0, '0, '0, '0, 2'b01, {4'd0, 4'd3});
    #2;
    check("after_bypass_p0", rd_readdata[0 +: DW], 32'hAABBCCDD);

    // Partial bypass: lanes 0 and 2 new, lanes 1 and 3 old.
    step(1'b1, 4'd5, 32'h11223344, 4'hF, 2'b00, '0);
    step(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 2'b10, {4'd5, 4'd0});
    #2;
    check("partial_bypass_p1", rd_readdata[DW +: DW], 32'h11BB33DD);

    // Output holds while rd_read is low, even as the word is rewritten.
    step(1'b1, 4'd2, 32'h55, 4'hF, 2'b00, '0);
    step(1'b0, '0, '0, '0, 2'b01, {4'd0, 4'd2});
    step(1'b1, 4'd2, 32'h66, 4'hF, 2'b00, {4'd2, 4'd2});
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 2'b00, {4'd2, 4'd2});
    #2;
    check("hold_p0", rd_readdata[0 +: DW], 32'h55);

    // Random traffic with rare resets.
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < NP; p++) ra[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      rr = NP'($urandom_range(0, (1 << NP) - 1));
      rst = ($urandom_range(0, 299) == 0);
      do_cycle(rst, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
               DW'($urandom), NL'($urandom_range(0, (1 << NL) - 1)), rr, ra, wq);
    end
    step(1'b0, '0, '0, '0, 2'b00, '0);

    // Uncleared 17-word instance: settle cycle, range checks, dropped write.
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    check("b_wait_settle", 32'(wr_waitrequest_b), 32'h1);
    rd_read_b = 1'b1;
    rd_address_b = 5'd4;
    @(posedge clk);
    #1;
    check("b_read_not_ready", rd_readdata_b, 32'h0);
    @(negedge clk);
    check("b_wait_ready", 32'(wr_waitrequest_b), 32'h0);
    rd_read_b = 1'b0;
    step_b(1'b1, 5'd4, 32'h04040404, 1'b0, 5'd0);
    step_b(1'b1, 5'd16, 32'h16161616, 1'b0, 5'd0);
    step_b(1'b1, 5'd20, 32'hDEADBEEF, 1'b0, 5'd0);
    step_b(1'b0, 5'd0, 32'h0, 1'b1, 5'd16);
    check("b_read16", rd_readdata_b, 32'h16161616);
    step_b(1'b0, 5'd0, 32'h0, 1'b1, 5'd17);
    check("b_read17", rd_readdata_b, 32'h0);
    step_b(1'b0, 5'd0, 32'h0, 1'b1, 5'd20);
    check("b_read20", rd_readdata_b, 32'h0);
    step_b(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    check("b_read4_intact", rd_readdata_b, 32'h04040404);

    // Let the monitor drain, then report.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
